// File: rtl/mips_instr_encoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_instr_encoder_pkg                                        |
// | Brief    : Shared types for the MIPS instruction encoder: encoder op     |
// |            enum, opcode/func field values, format classification and     |
// |            loader FSM state encoding.                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mips_instr_encoder_pkg;

  // Symbolic instruction request codes accepted by the encoder.
  typedef enum logic [4:0] {
    ENC_ADD     = 5'd0,
    ENC_ADDU    = 5'd1,
    ENC_SUB     = 5'd2,
    ENC_SUBU    = 5'd3,
    ENC_AND     = 5'd4,
    ENC_OR      = 5'd5,
    ENC_XOR     = 5'd6,
    ENC_NOR     = 5'd7,
    ENC_SLT     = 5'd8,
    ENC_SLTU    = 5'd9,
    ENC_SLL     = 5'd10,
    ENC_SRL     = 5'd11,
    ENC_SRA     = 5'd12,
    ENC_SLLV    = 5'd13,
    ENC_SRLV    = 5'd14,
    ENC_SRAV    = 5'd15,
    ENC_JR      = 5'd16,
    ENC_ADDI    = 5'd17,
    ENC_ADDIU   = 5'd18,
    ENC_ANDI    = 5'd19,
    ENC_ORI     = 5'd20,
    ENC_XORI    = 5'd21,
    ENC_LW      = 5'd22,
    ENC_SW      = 5'd23,
    ENC_BEQ     = 5'd24,
    ENC_BNE     = 5'd25,
    ENC_SLTI    = 5'd26,
    ENC_SLTIU   = 5'd27,
    ENC_LUI     = 5'd28,
    ENC_J       = 5'd29,
    ENC_JAL     = 5'd30,
    ENC_ILLEGAL = 5'd31
  } enc_op_e;

  // Primary opcode field values (bits 31:26).
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_SLTIU = 6'h0B;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_XORI  = 6'h0E;
  localparam logic [5:0] OPCODE_LUI   = 6'h0F;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  // R-type function field values (bits 5:0).
  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_SRA  = 6'h03;
  localparam logic [5:0] FUNC_SLLV = 6'h04;
  localparam logic [5:0] FUNC_SRLV = 6'h06;
  localparam logic [5:0] FUNC_SRAV = 6'h07;
  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;
  localparam logic [5:0] FUNC_NOR  = 6'h27;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;
  localparam logic [5:0] FUNC_SLTU = 6'h2B;

  // Instruction word layout selected by an op.
  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } enc_fmt_e;

  // Layout plus the 6-bit code (func for R-type, opcode otherwise).
  typedef struct packed {
    enc_fmt_e   fmt;
    logic [5:0] code;
  } enc_class_t;

  // Loader FSM states; VERIFY is reachable only in the readback build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } enc_state_e;

  // Map an op code to its word layout and opcode/func value.
  function automatic enc_class_t enc_classify(input logic [4:0] op);
    enc_class_t c;
    c.fmt  = FMT_BAD;
    c.code = 6'h00;
    case (op)
      ENC_ADD:   begin c.fmt = FMT_R; c.code = FUNC_ADD;     end
      ENC_ADDU:  begin c.fmt = FMT_R; c.code = FUNC_ADDU;    end
      ENC_SUB:   begin c.fmt = FMT_R; c.code = FUNC_SUB;     end
      ENC_SUBU:  begin c.fmt = FMT_R; c.code = FUNC_SUBU;    end
      ENC_AND:   begin c.fmt = FMT_R; c.code = FUNC_AND;     end
      ENC_OR:    begin c.fmt = FMT_R; c.code = FUNC_OR;      end
      ENC_XOR:   begin c.fmt = FMT_R; c.code = FUNC_XOR;     end
      ENC_NOR:   begin c.fmt = FMT_R; c.code = FUNC_NOR;     end
      ENC_SLT:   begin c.fmt = FMT_R; c.code = FUNC_SLT;     end
      ENC_SLTU:  begin c.fmt = FMT_R; c.code = FUNC_SLTU;    end
      ENC_SLL:   begin c.fmt = FMT_R; c.code = FUNC_SLL;     end
      ENC_SRL:   begin c.fmt = FMT_R; c.code = FUNC_SRL;     end
      ENC_SRA:   begin c.fmt = FMT_R; c.code = FUNC_SRA;     end
      ENC_SLLV:  begin c.fmt = FMT_R; c.code = FUNC_SLLV;    end
      ENC_SRLV:  begin c.fmt = FMT_R; c.code = FUNC_SRLV;    end
      ENC_SRAV:  begin c.fmt = FMT_R; c.code = FUNC_SRAV;    end
      ENC_JR:    begin c.fmt = FMT_R; c.code = FUNC_JR;      end
      ENC_ADDI:  begin c.fmt = FMT_I; c.code = OPCODE_ADDI;  end
      ENC_ADDIU: begin c.fmt = FMT_I; c.code = OPCODE_ADDIU; end
      ENC_ANDI:  begin c.fmt = FMT_I; c.code = OPCODE_ANDI;  end
      ENC_ORI:   begin c.fmt = FMT_I; c.code = OPCODE_ORI;   end
      ENC_XORI:  begin c.fmt = FMT_I; c.code = OPCODE_XORI;  end
      ENC_LW:    begin c.fmt = FMT_I; c.code = OPCODE_LW;    end
      ENC_SW:    begin c.fmt = FMT_I; c.code = OPCODE_SW;    end
      ENC_BEQ:   begin c.fmt = FMT_I; c.code = OPCODE_BEQ;   end
      ENC_BNE:   begin c.fmt = FMT_I; c.code = OPCODE_BNE;   end
      ENC_SLTI:  begin c.fmt = FMT_I; c.code = OPCODE_SLTI;  end
      ENC_SLTIU: begin c.fmt = FMT_I; c.code = OPCODE_SLTIU; end
      ENC_LUI:   begin c.fmt = FMT_I; c.code = OPCODE_LUI;   end
      ENC_J:     begin c.fmt = FMT_J; c.code = OPCODE_J;     end
      ENC_JAL:   begin c.fmt = FMT_J; c.code = OPCODE_JAL;   end
      default:   begin c.fmt = FMT_BAD; c.code = 6'h00;      end
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_instr_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_instr_pack                                               |
// | Brief    : Combinational packer: symbolic op + fields -> 32-bit MIPS     |
// |            word, with an illegal flag for unknown op codes. Fields that  |
// |            an op does not use are forced to zero in the packed word.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mips_instr_pack
  import mips_instr_encoder_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] index,
  output logic [31:0] word,
  output logic        illegal
);

  enc_class_t cls;
  logic       is_shift_imm;
  logic       is_jr;
  logic       is_lui;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic [4:0] f_sa;

  // Classify the op, zero the fields it does not use and assemble the word.
  always_comb begin
    cls          = enc_classify(op);
    is_shift_imm = (op == ENC_SLL) || (op == ENC_SRL) || (op == ENC_SRA);
    is_jr        = (op == ENC_JR);
    is_lui       = (op == ENC_LUI);
    // Constant shifts carry no rs; every other R-op carries no shift amount.
    f_rs         = is_shift_imm ? 5'd0 : rs;
    f_sa         = is_shift_imm ? sa : 5'd0;
    f_rt         = is_jr ? 5'd0 : rt;
    f_rd         = is_jr ? 5'd0 : rd;
    word         = 32'h0000_0000;
    illegal      = 1'b0;
    case (cls.fmt)
      FMT_R:   word = {OPCODE_RTYPE, f_rs, f_rt, f_rd, f_sa, cls.code};
      FMT_I:   word = {cls.code, (is_lui ? 5'd0 : rs), rt, imm};
      FMT_J:   word = {cls.code, index};
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_instr_encoder                                            |
// | Brief    : Boot/self-test program loader. Accepts symbolic instruction   |
// |            requests, packs them into MIPS words and writes them to       |
// |            consecutive imem addresses while holding the CPU in reset.    |
// |            Build option ENC_READBACK_EN adds a readback VERIFY cycle     |
// |            after every write and drives err_verify.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_index,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err_illegal,
  output logic              err_ovf,
  output logic              err_verify
);

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_ovf_q, err_ovf_d;

  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              handshake;
  logic              word_end;

  mips_instr_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .sa      (in_sa),
    .imm     (in_imm),
    .index   (in_index),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign handshake = in_valid && in_ready_q && (state_q == ST_ACCEPT);

`ifdef ENC_READBACK_EN
  logic err_verify_q, err_verify_d;
  // A word is finished once its readback cycle has been checked.
  assign word_end   = (state_q == ST_VERIFY);
  assign err_verify = err_verify_q;
`else
  logic unused_rdata;
  // Without readback a word is finished as soon as it has been written.
  assign word_end     = (state_q == ST_WRITE);
  assign err_verify   = 1'b0;
  assign unused_rdata = ^imem_rdata;
`endif

  // Next-state, pointer, sticky-flag and registered-output computation.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    last_d        = last_q;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    err_illegal_d = err_illegal_q;
    err_ovf_d     = err_ovf_q;
`ifdef ENC_READBACK_EN
    err_verify_d  = err_verify_q;
`endif
    if (start) begin
      // Restart from any state; takes priority over a simultaneous handshake.
      state_d       = ST_ACCEPT;
      ptr_d         = BASE_ADDR;
      last_d        = 1'b0;
      err_illegal_d = 1'b0;
      err_ovf_d     = 1'b0;
`ifdef ENC_READBACK_EN
      err_verify_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (handshake) begin
            if (pack_illegal) begin
              // Dropped: no write and no pointer movement.
              err_illegal_d = 1'b1;
              if (in_last) begin
                state_d = ST_DONE;
              end
            end else begin
              imem_addr_d  = ptr_q;
              imem_wdata_d = pack_word;
              last_d       = in_last;
              state_d      = ST_WRITE;
            end
          end
        end
`ifdef ENC_READBACK_EN
        ST_WRITE:  state_d = ST_VERIFY;
        ST_VERIFY: begin
          if (imem_rdata != imem_wdata_q) begin
            err_verify_d = 1'b1;
          end
        end
`endif
        default: ;
      endcase
      if (word_end) begin
        if (last_q) begin
          state_d = ST_DONE;
          if (ptr_q != PTR_MAX) begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end else if (ptr_q == PTR_MAX) begin
          // Address space exhausted before the program ended; never wrap.
          err_ovf_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          ptr_d   = ptr_q + PTR_ONE;
          state_d = ST_ACCEPT;
        end
      end
    end
    // Outputs are decoded from the next state so they register alongside it.
    in_ready_d = (state_d == ST_ACCEPT);
    imem_we_d  = (state_d == ST_WRITE);
    busy_d     = (state_d == ST_ACCEPT) || (state_d == ST_WRITE) || (state_d == ST_VERIFY);
    done_d     = (state_d == ST_DONE);
    cpu_hold_d = (state_d != ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= BASE_ADDR;
      last_q        <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= 32'h0000_0000;
      in_ready_q    <= 1'b0;
      imem_we_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cpu_hold_q    <= 1'b1;
      err_illegal_q <= 1'b0;
      err_ovf_q     <= 1'b0;
`ifdef ENC_READBACK_EN
      err_verify_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      last_q        <= last_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      in_ready_q    <= in_ready_d;
      imem_we_q     <= imem_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cpu_hold_q    <= cpu_hold_d;
      err_illegal_q <= err_illegal_d;
      err_ovf_q     <= err_ovf_d;
`ifdef ENC_READBACK_EN
      err_verify_q  <= err_verify_d;
`endif
    end
  end

  // A reset arriving during the write cycle aborts that pending write.
  assign imem_we     = imem_we_q & rst_n;
  assign in_ready    = in_ready_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cpu_hold    = cpu_hold_q;
  assign err_illegal = err_illegal_q;
  assign err_ovf     = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// Scoreboard bench for mips_instr_encoder: drivers push expected imem writes,
// a negedge monitor pops and compares them whenever imem_we is seen.
module tb_mips_instr_encoder;

  localparam int ADDR_W  = 4;
  localparam int MAX_PTR = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_sa = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_index = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       rdata_q = '0;
  logic              busy, done, cpu_hold, err_illegal, err_ovf, err_verify;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_sa(in_sa),
    .in_imm(in_imm), .in_index(in_index), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_rdata(rdata_q),
    .busy(busy), .done(done), .cpu_hold(cpu_hold),
    .err_illegal(err_illegal), .err_ovf(err_ovf), .err_verify(err_verify)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for the current session.
  int m_ptr = 0;
  bit m_done = 0, m_ill = 0, m_ovf = 0, m_ver = 0;

  // Function codes for ops 0..16 and opcodes for ops 17..28, from the ISA table.
  int rfunc [17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};
  int iopc  [12] = '{8, 9, 12, 13, 14, 35, 43, 4, 5, 10, 11, 15};

  // Instruction memory: write-first registered read, optional bit-0 corruption.
  logic [31:0] mem [0:MAX_PTR];
  bit corrupt = 0;
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    rdata_q <= (imem_we ? imem_wdata : mem[imem_addr]) ^ (corrupt ? 32'h1 : 32'h0);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  function automatic logic [31:0] ref_encode(int op, int rd, int rs, int rt, int sa, int imm, int idx);
    logic [31:0] w;
    if (op <= 16) begin
      if (op >= 10 && op <= 12) rs = 0; else sa = 0;
      if (op == 16) begin rt = 0; rd = 0; end
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sa) << 6) | 32'(rfunc[op]);
    end else if (op <= 28) begin
      if (op == 28) rs = 0;
      w = (32'(iopc[op-17]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm & 'hFFFF);
    end else begin
      w = (32'(op - 27) << 26) | 32'(idx & 'h3FF_FFFF);
    end
    return w;
  endfunction

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic begin_session();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    m_ptr = 0; m_done = 0; m_ill = 0; m_ovf = 0; m_ver = 0;
  endtask

  task automatic send(input int op, input int rd, input int rs, input int rt, input int sa,
                      input int imm, input int idx, input bit last, input logic [31:0] exp_word);
    int waited = 0;
    bit got = 0;
    in_op = 5'(op); in_rd = 5'(rd); in_rs = 5'(rs); in_rt = 5'(rt); in_sa = 5'(sa);
    in_imm = 16'(imm); in_index = 26'(idx); in_last = last; in_valid = 1'b1;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (in_ready) got = 1; else waited++;
    end
    if (got) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!got) begin
      check("handshake_timeout", 32'd0, 32'd1);
      return;
    end
    if (op == 31) begin
      m_ill = 1;
      if (last) m_done = 1;
    end else begin
      exp_q.push_back('{m_ptr, exp_word});
      if (last) m_done = 1;
      else if (m_ptr == MAX_PTR) begin m_ovf = 1; m_done = 1; end
      else m_ptr++;
    end
  endtask

  task automatic send_rand(input bit last, input bit allow_illegal);
    int op, rd, rs, rt, sa, imm, idx;
    op  = (allow_illegal && $urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 30));
    rd  = $urandom_range(0, 31); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
    sa  = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
    idx = int'($urandom & 32'h03FF_FFFF);
    send(op, rd, rs, rt, sa, imm, idx, last, ref_encode(op, rd, rs, rt, sa, imm, idx));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_session(input string tag);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!m_done));
    check({tag, "_busy"}, 32'(busy), 32'(!m_done));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_err_illegal"}, 32'(err_illegal), 32'(m_ill));
    check({tag, "_err_ovf"}, 32'(err_ovf), 32'(m_ovf));
    check({tag, "_err_verify"}, 32'(err_verify), 32'(m_ver));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_err_illegal"}, 32'(err_illegal), 32'd0);
    check({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
    check({tag, "_err_verify"}, 32'(err_verify), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    rst_n = 1'b1;

    // Single ADDU (nonzero sa must be dropped) as the last word
    begin_session();
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    send(1, 3, 1, 2, 9, 0, 0, 1'b1, 32'h0022_1821);
    wait_done();
    check_session("addu");

    // ADDI / LW / JR program (JR with junk rd/rt/sa)
    begin_session();
    send(17, 0, 0, 8, 0, 5, 0, 1'b0, 32'h2008_0005);
    send(22, 0, 29, 4, 0, 8, 0, 1'b0, 32'h8FA4_0008);
    send(16, 5, 31, 6, 3, 0, 0, 1'b1, 32'h03E0_0008);
    wait_done();
    check_session("prog3");

    // Shift with forced rs, LUI with forced rs, J and JAL
    begin_session();
    send(10, 2, 7, 3, 4, 0, 0, 1'b0, 32'h0003_1100);
    send(28, 0, 5, 1, 0, 16'h1234, 0, 1'b0, 32'h3C01_1234);
    send(29, 0, 0, 0, 0, 0, 26'h10, 1'b0, 32'h0800_0010);
    send(30, 0, 0, 0, 0, 0, 26'h10, 1'b1, 32'h0C00_0010);
    wait_done();
    check_session("shift_jump");

    // Illegal op between two legal ones
    begin_session();
    send(5, 1, 2, 3, 0, 0, 0, 1'b0, 32'h0043_0825);
    send(31, 1, 2, 3, 4, 5, 6, 1'b0, 32'h0);
    send(0, 4, 5, 6, 0, 0, 0, 1'b1, 32'h00A6_2020);
    wait_done();
    check_session("illegal_mid");

    // Illegal op carrying last ends the session with no write
    begin_session();
    send(31, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0);
    wait_done();
    check_session("illegal_last");

    // Randomized sessions
    for (int s = 0; s < 3; s++) begin
      begin_session();
      for (int i = 0; i < 12; i++) send_rand(1'b0, 1'b1);
      send_rand(1'b1, 1'b0);
      wait_done();
      check_session("random");
    end

    // Address space exhaustion
    begin_session();
    for (int i = 0; i <= MAX_PTR; i++) send_rand(1'b0, 1'b0);
    wait_done();
    check_session("overflow");
    in_valid = 1'b1; in_op = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_no_accept", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Restart mid-session
    begin_session();
    for (int i = 0; i < 3; i++) send_rand(1'b0, 1'b0);
    begin_session();
    send_rand(1'b0, 1'b0);
    send_rand(1'b1, 1'b0);
    wait_done();
    check_session("restart");

    // Reset right after a handshake aborts the write
    begin_session();
    send(1, 3, 1, 2, 0, 0, 0, 1'b0, 32'h0022_1821);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_imem_we", 32'(imem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset("abort");
    exp_q.delete();

`ifdef ENC_READBACK_EN
    // Corrupted readback
    begin_session();
    corrupt = 1;
    send(1, 3, 1, 2, 0, 0, 0, 1'b1, 32'h0022_1821);
    m_ver = 1;
    wait_done();
    corrupt = 0;
    check_session("verify");
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
